// File: rtl/rggen_rtl_pkg.sv
// Shared types for the rggen RTL slice: bus status codes and the initiator FSM states.
package rggen_rtl_pkg;

  typedef enum logic [1:0] {
    RGGEN_OKAY         = 2'b00,
    RGGEN_EXOKAY       = 2'b01,
    RGGEN_SLAVE_ERROR  = 2'b10,
    RGGEN_DECODE_ERROR = 2'b11
  } rggen_status;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    REQUEST  = 2'b01,
    RESPONSE = 2'b10
  } rggen_bus_initiator_state;

endpackage

// File: rtl/rggen_bus_if.sv
// Register bus between an initiator (master) and an rggen register block (slave).
interface rggen_bus_if #(
  parameter int unsigned ADDRESS_WIDTH = 16,
  parameter int unsigned BUS_WIDTH     = 32
);
  import rggen_rtl_pkg::*;

  logic                     valid;
  logic                     write;
  logic [ADDRESS_WIDTH-1:0] address;
  logic [BUS_WIDTH-1:0]     write_data;
  logic [BUS_WIDTH/8-1:0]   strobe;
  logic                     ready;
  logic [BUS_WIDTH-1:0]     read_data;
  rggen_status              status;

  modport master (
    output valid, write, address, write_data, strobe,
    input  ready, read_data, status
  );

  modport slave (
    input  valid, write, address, write_data, strobe,
    output ready, read_data, status
  );
endinterface

// File: rtl/rggen_bus_initiator_timer.sv
// Saturating wait counter that flags a bus request left unanswered for TIMEOUT_CYCLES cycles.
module rggen_bus_initiator_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 8
)(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_start,
  input  logic i_enable,
  input  logic i_ready,
  output logic o_expired
);
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Clear on request entry, count idle request cycles, hold at all-ones.
  always_comb begin
    count_d = count_q;
    if (i_start) begin
      count_d = '0;
    end else if (i_enable && !i_ready && (count_q != '1)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) count_q <= '0;
    else          count_q <= count_d;
  end

  assign o_expired = i_enable && !i_ready && (count_q == CNT_W'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/rggen_bus_initiator.sv
// Single-outstanding command/response engine acting as master on rggen_bus_if.
module rggen_bus_initiator
  import rggen_rtl_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH   = 16,
  parameter int unsigned BUS_WIDTH       = 32,
  parameter int unsigned TIMEOUT_CYCLES  = 0,
  parameter bit          CHECK_ALIGNMENT = 1'b1
)(
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_cmd_valid,
  output logic                     o_cmd_ready,
  input  logic [ADDRESS_WIDTH-1:0] i_cmd_address,
  input  logic                     i_cmd_write,
  input  logic [BUS_WIDTH-1:0]     i_cmd_write_data,
  input  logic [BUS_WIDTH/8-1:0]   i_cmd_strobe,
  output logic                     o_rsp_valid,
  input  logic                     i_rsp_ready,
  output logic [BUS_WIDTH-1:0]     o_rsp_read_data,
  output rggen_status              o_rsp_status,
  output logic                     o_rsp_timeout,
  rggen_bus_if.master              bus_if
);
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_MASK = ADDRESS_WIDTH'(BUS_WIDTH / 8 - 1);

  rggen_bus_initiator_state state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] address_q, address_d;
  logic                     write_q, write_d;
  logic [BUS_WIDTH-1:0]     write_data_q, write_data_d;
  logic [BUS_WIDTH/8-1:0]   strobe_q, strobe_d;
  logic [BUS_WIDTH-1:0]     read_data_q, read_data_d;
  rggen_status              status_q, status_d;
  logic                     timeout_q, timeout_d;
  logic                     misaligned;
  logic                     timeout_expired;

  assign misaligned = CHECK_ALIGNMENT && ((i_cmd_address & ADDR_MASK) != '0);

  // Next-state and captured command/response fields.
  always_comb begin
    state_d      = state_q;
    address_d    = address_q;
    write_d      = write_q;
    write_data_d = write_data_q;
    strobe_d     = strobe_q;
    read_data_d  = read_data_q;
    status_d     = status_q;
    timeout_d    = timeout_q;
    case (state_q)
      IDLE: begin
        if (i_cmd_valid) begin
          address_d    = i_cmd_address;
          write_d      = i_cmd_write;
          write_data_d = i_cmd_write_data;
          strobe_d     = i_cmd_write ? i_cmd_strobe : '1;
          read_data_d  = '0;
          timeout_d    = 1'b0;
          if (misaligned) begin
            status_d = RGGEN_SLAVE_ERROR;
            state_d  = RESPONSE;
          end else begin
            state_d  = REQUEST;
          end
        end
      end
      REQUEST: begin
        // A ready arriving in the expiry cycle takes priority over the timeout.
        if (bus_if.ready) begin
          read_data_d = write_q ? '0 : bus_if.read_data;
          status_d    = bus_if.status;
          timeout_d   = 1'b0;
          state_d     = RESPONSE;
        end else if (timeout_expired) begin
          read_data_d = '0;
          status_d    = RGGEN_SLAVE_ERROR;
          timeout_d   = 1'b1;
          state_d     = RESPONSE;
        end
      end
      RESPONSE: begin
        if (i_rsp_ready) begin
          timeout_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and field registers; reset also drops the bus request.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      address_q    <= '0;
      write_q      <= 1'b0;
      write_data_q <= '0;
      strobe_q     <= '0;
      read_data_q  <= '0;
      status_q     <= RGGEN_OKAY;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      address_q    <= address_d;
      write_q      <= write_d;
      write_data_q <= write_data_d;
      strobe_q     <= strobe_d;
      read_data_q  <= read_data_d;
      status_q     <= status_d;
      timeout_q    <= timeout_d;
    end
  end

  generate
    if (TIMEOUT_CYCLES > 0) begin : g_timer
      logic timer_start;
      logic timer_enable;
      assign timer_start  = (state_q == IDLE) && (state_d == REQUEST);
      assign timer_enable = (state_q == REQUEST);
      rggen_bus_initiator_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
      ) u_timer (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_start   (timer_start),
        .i_enable  (timer_enable),
        .i_ready   (bus_if.ready),
        .o_expired (timeout_expired)
      );
    end else begin : g_no_timer
      assign timeout_expired = 1'b0;
    end
  endgenerate

  assign o_cmd_ready       = (state_q == IDLE);
  assign o_rsp_valid       = (state_q == RESPONSE);
  assign o_rsp_read_data   = read_data_q;
  assign o_rsp_status      = status_q;
  assign o_rsp_timeout     = timeout_q;
  assign bus_if.valid      = (state_q == REQUEST);
  assign bus_if.write      = write_q;
  assign bus_if.address    = address_q;
  assign bus_if.write_data = write_data_q;
  assign bus_if.strobe     = strobe_q;

`ifdef RGGEN_ENABLE_SVA
  a_bus_stable: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (bus_if.valid && !bus_if.ready && !timeout_expired) |=>
      (bus_if.valid && $stable(bus_if.address) && $stable(bus_if.write) &&
       $stable(bus_if.write_data) && $stable(bus_if.strobe)));
  a_rsp_stable: assert property (@(posedge i_clk) disable iff (!i_rsp_ready && 1'b0 || !i_rst_n)
    (o_rsp_valid && !i_rsp_ready) |=>
      (o_rsp_valid && $stable(o_rsp_read_data) && $stable(o_rsp_status) && $stable(o_rsp_timeout)));
  a_no_overlap: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(o_cmd_ready && o_rsp_valid));
`endif
endmodule

// File: tb/tb_rggen_bus_initiator.sv
// Randomized self-checking bench for rggen_bus_initiator with a transaction-level reference model.
module tb_rggen_bus_initiator;
  import rggen_rtl_pkg::*;

  localparam int unsigned TO = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_address;
  logic        cmd_write;
  logic [31:0] cmd_write_data;
  logic [3:0]  cmd_strobe;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_read_data;
  rggen_status rsp_status;
  logic        rsp_timeout;

  int unsigned total = 0;
  int unsigned bad   = 0;

  rggen_bus_if #(.ADDRESS_WIDTH(16), .BUS_WIDTH(32)) bus_if ();

  rggen_bus_initiator #(
    .ADDRESS_WIDTH   (16),
    .BUS_WIDTH       (32),
    .TIMEOUT_CYCLES  (TO),
    .CHECK_ALIGNMENT (1'b1)
  ) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_cmd_valid      (cmd_valid),
    .o_cmd_ready      (cmd_ready),
    .i_cmd_address    (cmd_address),
    .i_cmd_write      (cmd_write),
    .i_cmd_write_data (cmd_write_data),
    .i_cmd_strobe     (cmd_strobe),
    .o_rsp_valid      (rsp_valid),
    .i_rsp_ready      (rsp_ready),
    .o_rsp_read_data  (rsp_read_data),
    .o_rsp_status     (rsp_status),
    .o_rsp_timeout    (rsp_timeout),
    .bus_if           (bus_if)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issues one command at the current falling edge, plays the slave, consumes the response.
  // wait_n = idle request cycles before the slave answers; >= TO means it never answers.
  task automatic run_txn(input logic [15:0] addr, input logic wr, input logic [31:0] wdata,
                         input logic [3:0] strb, input int unsigned wait_n,
                         input logic [1:0] s_status, input logic [31:0] s_data,
                         input int unsigned hold);
    logic        mis;
    logic        to;
    int unsigned exp_vcyc;
    logic [1:0]  exp_status;
    logic [31:0] exp_data;
    logic [3:0]  exp_strb;
    int unsigned vcyc;
    int unsigned lat;
    logic        seen;

    mis        = (addr % 4) != 0;
    to         = !mis && (wait_n >= TO);
    exp_vcyc   = mis ? 0 : (to ? TO : wait_n + 1);
    exp_status = (mis || to) ? 2'(RGGEN_SLAVE_ERROR) : s_status;
    exp_data   = (mis || to || wr) ? 32'h0 : s_data;
    exp_strb   = wr ? strb : 4'hF;

    check_value("cmd_ready_idle", cmd_ready, 1);
    cmd_valid      = 1'b1;
    cmd_address    = addr;
    cmd_write      = wr;
    cmd_write_data = wdata;
    cmd_strobe     = strb;

    vcyc = 0;
    lat  = 0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      cmd_valid      = 1'b0;
      cmd_address    = 16'($urandom);
      cmd_write      = 1'($urandom);
      cmd_write_data = $urandom;
      cmd_strobe     = 4'($urandom);
      bus_if.ready   = 1'b0;
      lat++;
      if (rsp_valid) begin
        seen      = 1'b1;
        rsp_ready = 1'b0;
      end else begin
        rsp_ready = 1'($urandom);
        check_value("cmd_ready_busy", cmd_ready, 0);
        if (bus_if.valid) begin
          vcyc++;
          check_value("bus_addr", bus_if.address, addr);
          check_value("bus_write", bus_if.write, wr);
          check_value("bus_wdata", bus_if.write_data, wdata);
          check_value("bus_strobe", bus_if.strobe, exp_strb);
          if (vcyc == wait_n + 1) begin
            bus_if.ready     = 1'b1;
            bus_if.status    = rggen_status'(s_status);
            bus_if.read_data = s_data;
          end
        end
      end
    end

    check_value("rsp_seen", seen, 1);
    check_value("latency", lat, exp_vcyc + 1);
    check_value("valid_cycles", vcyc, exp_vcyc);
    check_value("bus_valid_rsp", bus_if.valid, 0);
    check_value("rsp_data", rsp_read_data, exp_data);
    check_value("rsp_status", rsp_status, exp_status);
    check_value("rsp_timeout", rsp_timeout, to);

    for (int k = 0; k < int'(hold); k++) begin
      @(negedge clk);
      check_value("hold_valid", rsp_valid, 1);
      check_value("hold_cmd_ready", cmd_ready, 0);
      check_value("hold_data", rsp_read_data, exp_data);
      check_value("hold_status", rsp_status, exp_status);
      check_value("hold_timeout", rsp_timeout, to);
      check_value("hold_bus_valid", bus_if.valid, 0);
    end

    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check_value("done_rsp_valid", rsp_valid, 0);
    check_value("done_cmd_ready", cmd_ready, 1);
    check_value("done_timeout", rsp_timeout, 0);
  endtask

  initial begin
    logic [15:0] a;
    rst_n            = 1'b0;
    cmd_valid        = 1'b0;
    cmd_address      = '0;
    cmd_write        = 1'b0;
    cmd_write_data   = '0;
    cmd_strobe       = '0;
    rsp_ready        = 1'b0;
    bus_if.ready     = 1'b0;
    bus_if.read_data = '0;
    bus_if.status    = RGGEN_OKAY;

    repeat (2) @(negedge clk);
    check_value("rst_cmd_ready", cmd_ready, 1);
    check_value("rst_rsp_valid", rsp_valid, 0);
    check_value("rst_rsp_data", rsp_read_data, 0);
    check_value("rst_rsp_status", rsp_status, RGGEN_OKAY);
    check_value("rst_rsp_timeout", rsp_timeout, 0);
    check_value("rst_bus_valid", bus_if.valid, 0);
    check_value("rst_bus_addr", bus_if.address, 0);
    check_value("rst_bus_write", bus_if.write, 0);
    check_value("rst_bus_wdata", bus_if.write_data, 0);
    check_value("rst_bus_strobe", bus_if.strobe, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_txn(16'h0010, 1'b1, 32'hDEADBEEF, 4'hF, 3, 2'(RGGEN_OKAY), 32'hCAFE0001, 0);
    run_txn(16'h0004, 1'b0, 32'h0BADF00D, 4'h0, 0, 2'(RGGEN_OKAY), 32'h12345678, 0);
    run_txn(16'h0008, 1'b0, 32'h0, 4'h0, 30, 2'(RGGEN_OKAY), 32'h11111111, 1);
    run_txn(16'h000C, 1'b0, 32'h0, 4'h0, TO - 1, 2'(RGGEN_SLAVE_ERROR), 32'h000000A5, 0);
    run_txn(16'h0002, 1'b0, 32'h0, 4'h0, 0, 2'(RGGEN_OKAY), 32'h22222222, 5);

    // Reset in the middle of a request.
    cmd_valid   = 1'b1;
    cmd_address = 16'h0020;
    cmd_write   = 1'b0;
    repeat (3) @(negedge clk);
    cmd_valid = 1'b0;
    check_value("pre_rst_bus_valid", bus_if.valid, 1);
    rst_n = 1'b0;
    #1;
    check_value("async_bus_valid", bus_if.valid, 0);
    check_value("async_rsp_valid", rsp_valid, 0);
    check_value("async_cmd_ready", cmd_ready, 1);
    check_value("async_bus_addr", bus_if.address, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_value("post_rst_cmd_ready", cmd_ready, 1);
    run_txn(16'h0024, 1'b0, 32'h0, 4'h0, 1, 2'(RGGEN_EXOKAY), 32'h87654321, 0);

    for (int n = 0; n < 40; n++) begin
      a = 16'($urandom);
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      run_txn(a, 1'($urandom), $urandom, 4'($urandom), $urandom_range(0, 10),
              2'($urandom), $urandom, $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
